// File: rtl/johnson_phase_decoder.sv
// Johnson-code phase decoder: registers the upstream ring-counter code, decodes it to a phase index
// and one-hot phase, and runs a SEARCH/LOCKED/ERROR lock monitor. Optional macro: JPD_ALLOW_HOLD_EN.
module johnson_phase_decoder #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int REV_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N-1:0]              q_in,
    input  logic                      clear_err,
    output logic [$clog2(2*N)-1:0]    phase_idx,
    output logic [2*N-1:0]            phase_onehot,
    output logic                      phase_valid,
    output logic                      locked,
    output logic                      illegal,
    output logic                      seq_err,
    output logic                      err_sticky,
    output logic [REV_W-1:0]          rev_count
);

    localparam int              IDX_W       = $clog2(2*N);
    localparam int              SEQ_LEN     = 2*N;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SEQ_LEN-1);
    localparam logic [3:0]      LOCK_TARGET = 4'(LOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        ERROR  = 2'd2
    } stateT;

    stateT              state_q, state_d;
    logic [N-1:0]       qR_q;
    logic [3:0]         goodCnt_q, goodCnt_d;
    logic               prevValid_q, prevValid_d;
    logic [IDX_W-1:0]   prevIdx_q, prevIdx_d;

    logic [IDX_W-1:0]   phaseIdx_q, phaseIdx_d;
    logic [2*N-1:0]     phaseOnehot_q, phaseOnehot_d;
    logic               phaseValid_q, phaseValid_d;
    logic               locked_q, locked_d;
    logic               illegal_q, illegal_d;
    logic               seqErr_q, seqErr_d;
    logic               errSticky_q, errSticky_d;
    logic [REV_W-1:0]   revCount_q, revCount_d;

    int                 onesCnt;
    logic [N-1:0]       thermo;
    logic               codeLegal;
    logic [IDX_W-1:0]   codeIdx;
    logic [IDX_W-1:0]   nextIdx;
    logic               correctStep;
    logic               wrapStep;
    logic               holdStep;

    // A legal code is a thermometer pattern: ones filling from the LSB while the MSB is clear,
    // zeros filling from the LSB once it is set.
    always_comb begin
        onesCnt   = 0;
        thermo    = '0;
        codeLegal = 1'b0;
        codeIdx   = '0;
        for (int i = 0; i < N; i++) begin
            if (qR_q[i]) onesCnt++;
        end
        if (!qR_q[N-1]) begin
            for (int i = 0; i < N; i++) thermo[i] = (i < onesCnt);
            codeLegal = (qR_q == thermo);
            codeIdx   = IDX_W'(onesCnt);
        end else begin
            for (int i = 0; i < N; i++) thermo[i] = (i >= (N - onesCnt));
            codeLegal = (qR_q == thermo);
            codeIdx   = IDX_W'(SEQ_LEN - onesCnt);
        end
    end

    assign nextIdx     = (prevIdx_q == LAST_IDX) ? '0 : (prevIdx_q + IDX_W'(1));
    assign correctStep = codeLegal && prevValid_q && (codeIdx == nextIdx);
    assign wrapStep    = correctStep && (prevIdx_q == LAST_IDX);

`ifdef JPD_ALLOW_HOLD_EN
    // A stalled upstream counter repeats its code; treat that as neither progress nor error.
    assign holdStep = codeLegal && prevValid_q && (codeIdx == prevIdx_q);
`else
    assign holdStep = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        goodCnt_d     = goodCnt_q;
        revCount_d    = revCount_q;
        illegal_d     = !codeLegal;
        seqErr_d      = 1'b0;
        prevValid_d   = codeLegal;
        prevIdx_d     = codeLegal ? codeIdx : prevIdx_q;
        phaseValid_d  = codeLegal;
        phaseIdx_d    = codeLegal ? codeIdx : phaseIdx_q;
        phaseOnehot_d = '0;
        if (codeLegal) phaseOnehot_d[codeIdx] = 1'b1;

        case (state_q)
            SEARCH: begin
                if (correctStep) begin
                    if ((goodCnt_q + 4'd1) == LOCK_TARGET) begin
                        state_d   = LOCKED;
                        goodCnt_d = '0;
                    end else begin
                        goodCnt_d = goodCnt_q + 4'd1;
                    end
                end else if (!holdStep) begin
                    goodCnt_d = '0;
                end
            end
            LOCKED: begin
                if (!codeLegal) begin
                    state_d   = ERROR;
                    goodCnt_d = '0;
                end else if (correctStep) begin
                    if (wrapStep) revCount_d = revCount_q + REV_W'(1);
                end else if (!holdStep) begin
                    seqErr_d  = 1'b1;
                    state_d   = ERROR;
                    goodCnt_d = '0;
                end
            end
            ERROR: begin
                state_d   = SEARCH;
                goodCnt_d = '0;
            end
            default: begin
                state_d   = SEARCH;
                goodCnt_d = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
        // A new error outranks a simultaneous clear so no event is ever lost.
        if (illegal_d || seqErr_d) begin
            errSticky_d = 1'b1;
        end else if (clear_err) begin
            errSticky_d = 1'b0;
        end else begin
            errSticky_d = errSticky_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= SEARCH;
            qR_q          <= '0;
            goodCnt_q     <= '0;
            prevValid_q   <= 1'b0;
            prevIdx_q     <= '0;
            phaseIdx_q    <= '0;
            phaseOnehot_q <= '0;
            phaseValid_q  <= 1'b0;
            locked_q      <= 1'b0;
            illegal_q     <= 1'b0;
            seqErr_q      <= 1'b0;
            errSticky_q   <= 1'b0;
            revCount_q    <= '0;
        end else begin
            state_q       <= state_d;
            qR_q          <= q_in;
            goodCnt_q     <= goodCnt_d;
            prevValid_q   <= prevValid_d;
            prevIdx_q     <= prevIdx_d;
            phaseIdx_q    <= phaseIdx_d;
            phaseOnehot_q <= phaseOnehot_d;
            phaseValid_q  <= phaseValid_d;
            locked_q      <= locked_d;
            illegal_q     <= illegal_d;
            seqErr_q      <= seqErr_d;
            errSticky_q   <= errSticky_d;
            revCount_q    <= revCount_d;
        end
    end

    assign phase_idx    = phaseIdx_q;
    assign phase_onehot = phaseOnehot_q;
    assign phase_valid  = phaseValid_q;
    assign locked       = locked_q;
    assign illegal      = illegal_q;
    assign seq_err      = seqErr_q;
    assign err_sticky   = errSticky_q;
    assign rev_count    = revCount_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench for johnson_phase_decoder: directed rows push hand-computed expected outputs,
// a monitor pops one entry per clock and compares it with the registered outputs.
module tb_johnson_phase_decoder;

    localparam logic [3:0] C0  = 4'b0000;
    localparam logic [3:0] C1  = 4'b0001;
    localparam logic [3:0] C2  = 4'b0011;
    localparam logic [3:0] C3  = 4'b0111;
    localparam logic [3:0] C4  = 4'b1111;
    localparam logic [3:0] C5  = 4'b1110;
    localparam logic [3:0] C6  = 4'b1100;
    localparam logic [3:0] C7  = 4'b1000;
    localparam logic [3:0] ILL = 4'b0101;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] onehot;
        logic       valid;
        logic       locked;
        logic       ill;
        logic       seq;
        logic       sticky;
        logic [7:0] rev;
    } obsT;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] q_in = 4'b0000;
    logic       clear_err = 1'b0;
    logic [2:0] phase_idx;
    logic [7:0] phase_onehot;
    logic       phase_valid;
    logic       locked;
    logic       illegal;
    logic       seq_err;
    logic       err_sticky;
    logic [7:0] rev_count;

    obsT expQ[$];
    int  rowQ[$];
    int  total = 0;
    int  bad = 0;
    int  rowNum = 0;

    johnson_phase_decoder #(.N(4), .LOCK_CNT(3), .REV_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .q_in         (q_in),
        .clear_err    (clear_err),
        .phase_idx    (phase_idx),
        .phase_onehot (phase_onehot),
        .phase_valid  (phase_valid),
        .locked       (locked),
        .illegal      (illegal),
        .seq_err      (seq_err),
        .err_sticky   (err_sticky),
        .rev_count    (rev_count)
    );

    always #5 clock = ~clock;

    // Drive one row before the next rising edge and queue the outputs expected after that edge.
    task automatic applyStimulus(input logic rstN, input logic [3:0] q, input logic clr,
                                 input int eIdx, input bit eValid, input bit eLocked,
                                 input bit eIll, input bit eSeq, input bit eSticky, input int eRev);
        obsT e;
        @(negedge clock);
        reset     = rstN;
        q_in      = q;
        clear_err = clr;
        e.idx     = 3'(eIdx);
        e.onehot  = eValid ? (8'd1 << eIdx) : 8'd0;
        e.valid   = eValid;
        e.locked  = eLocked;
        e.ill     = eIll;
        e.seq     = eSeq;
        e.sticky  = eSticky;
        e.rev     = 8'(eRev);
        rowNum++;
        expQ.push_back(e);
        rowQ.push_back(rowNum);
    endtask

    task automatic checkOutput();
        obsT e;
        obsT got;
        int  r;
        e   = expQ.pop_front();
        r   = rowQ.pop_front();
        got = '{idx: phase_idx, onehot: phase_onehot, valid: phase_valid, locked: locked,
                ill: illegal, seq: seq_err, sticky: err_sticky, rev: rev_count};
        total++;
        if (got !== e) begin
            bad++;
            $display("[TB] FAIL row%0d: got idx=%0d oh=%b v=%b lk=%b ill=%b seq=%b st=%b rev=%0d, want idx=%0d oh=%b v=%b lk=%b ill=%b seq=%b st=%b rev=%0d",
                     r, got.idx, got.onehot, got.valid, got.locked, got.ill, got.seq, got.sticky, got.rev,
                     e.idx, e.onehot, e.valid, e.locked, e.ill, e.seq, e.sticky, e.rev);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) checkOutput();
        end
    end

    initial begin
        // Reset held for three edges, then lock on 0000,0001,0011,0111
        for (int i = 0; i < 3; i++) applyStimulus(0, C0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, C0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, C1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, C2, 0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, C3, 0, 2, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, C4, 0, 3, 1, 1, 0, 0, 0, 0);
        // Two revolutions while locked
        applyStimulus(1, C5, 0, 4, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, C6, 0, 5, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, C7, 0, 6, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, C0, 0, 7, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, C1, 0, 0, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, C2, 0, 1, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, C3, 0, 2, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, C4, 0, 3, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, C5, 0, 4, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, C6, 0, 5, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, C7, 0, 6, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, C0, 0, 7, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, C1, 0, 0, 1, 1, 0, 0, 0, 2);
        applyStimulus(1, C2, 0, 1, 1, 1, 0, 0, 0, 2);
        applyStimulus(1, C3, 0, 2, 1, 1, 0, 0, 0, 2);
        // Illegal code injected, then relock after the error cycle plus three steps
        applyStimulus(1, ILL, 0, 3, 1, 1, 0, 0, 0, 2);
        applyStimulus(1, C4, 0, 3, 0, 0, 1, 0, 1, 2);
        applyStimulus(1, C5, 0, 4, 1, 0, 0, 0, 1, 2);
        applyStimulus(1, C6, 0, 5, 1, 0, 0, 0, 1, 2);
        applyStimulus(1, C7, 0, 6, 1, 0, 0, 0, 1, 2);
        applyStimulus(1, C0, 0, 7, 1, 1, 0, 0, 1, 2);
        applyStimulus(1, C1, 0, 0, 1, 1, 0, 0, 1, 3);
        applyStimulus(1, C2, 0, 1, 1, 1, 0, 0, 1, 3);
        // Skip 0011 -> 1111
        applyStimulus(1, C4, 0, 2, 1, 1, 0, 0, 1, 3);
        applyStimulus(1, C5, 0, 4, 1, 0, 0, 1, 1, 3);
        applyStimulus(1, C6, 0, 5, 1, 0, 0, 0, 1, 3);
        applyStimulus(1, C7, 0, 6, 1, 0, 0, 0, 1, 3);
        applyStimulus(1, C0, 0, 7, 1, 0, 0, 0, 1, 3);
        applyStimulus(1, C1, 0, 0, 1, 1, 0, 0, 1, 3);
        // Run up to rev_count=5 while locked
        applyStimulus(1, C2, 0, 1, 1, 1, 0, 0, 1, 3);
        applyStimulus(1, C3, 0, 2, 1, 1, 0, 0, 1, 3);
        applyStimulus(1, C4, 0, 3, 1, 1, 0, 0, 1, 3);
        applyStimulus(1, C5, 0, 4, 1, 1, 0, 0, 1, 3);
        applyStimulus(1, C6, 0, 5, 1, 1, 0, 0, 1, 3);
        applyStimulus(1, C7, 0, 6, 1, 1, 0, 0, 1, 3);
        applyStimulus(1, C0, 0, 7, 1, 1, 0, 0, 1, 3);
        applyStimulus(1, C1, 0, 0, 1, 1, 0, 0, 1, 4);
        applyStimulus(1, C2, 0, 1, 1, 1, 0, 0, 1, 4);
        applyStimulus(1, C3, 0, 2, 1, 1, 0, 0, 1, 4);
        applyStimulus(1, C4, 0, 3, 1, 1, 0, 0, 1, 4);
        applyStimulus(1, C5, 0, 4, 1, 1, 0, 0, 1, 4);
        applyStimulus(1, C6, 0, 5, 1, 1, 0, 0, 1, 4);
        applyStimulus(1, C7, 0, 6, 1, 1, 0, 0, 1, 4);
        applyStimulus(1, C0, 0, 7, 1, 1, 0, 0, 1, 4);
        applyStimulus(1, C1, 0, 0, 1, 1, 0, 0, 1, 5);
        // Mid-operation reset for one edge
        applyStimulus(0, C2, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, C0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, C1, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, C2, 0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, C3, 0, 2, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, C3, 0, 3, 1, 1, 0, 0, 0, 0);
        // Repeated 0111 while locked
`ifdef JPD_ALLOW_HOLD_EN
        applyStimulus(1, C4, 0, 3, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, C5, 0, 4, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, C6, 0, 5, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, C7, 0, 6, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, C0, 0, 7, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, C1, 0, 0, 1, 1, 0, 0, 0, 1);
        applyStimulus(1, C3, 0, 1, 1, 1, 0, 0, 0, 1);
`else
        applyStimulus(1, C4, 0, 3, 1, 0, 0, 1, 1, 0);
        applyStimulus(1, C5, 0, 4, 1, 0, 0, 0, 1, 0);
        applyStimulus(1, C6, 0, 5, 1, 0, 0, 0, 1, 0);
        applyStimulus(1, C7, 0, 6, 1, 0, 0, 0, 1, 0);
        applyStimulus(1, C0, 0, 7, 1, 1, 0, 0, 1, 0);
        applyStimulus(1, C1, 0, 0, 1, 1, 0, 0, 1, 1);
        applyStimulus(1, C3, 0, 1, 1, 1, 0, 0, 1, 1);
`endif
        // Clear together with a new seq_err keeps the flag; clear alone drops it
        applyStimulus(1, C4, 1, 3, 1, 0, 0, 1, 1, 1);
        applyStimulus(1, C5, 1, 4, 1, 0, 0, 0, 0, 1);
        applyStimulus(1, C6, 0, 5, 1, 0, 0, 0, 0, 1);
        applyStimulus(1, C6, 0, 6, 1, 0, 0, 0, 0, 1);

        for (int i = 0; i < 10; i++) begin
            if (expQ.size() == 0) break;
            @(posedge clock);
            #2;
        end
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: pending=%0d want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
